// File: rtl/add36_seq_ctrl.sv
// Multi-cycle staging wrapper around a 36-bit ripple-carry adder with valid/ready handshake.
// Optional signed-overflow output Ovf is enabled by defining ADD36_OVF_EN.
module add36_seq_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [35:0] A,
  input  logic [35:0] B,
  input  logic        sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [35:0] S,
  output logic        Cout
`ifdef ADD36_OVF_EN
  ,
  output logic        Ovf
`endif
);

  typedef enum logic [1:0] {StIdle, StSettle, StDone} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [35:0]        ar_q, ar_d, br_q, br_d;
  logic               cr_q, cr_d;
  logic [35:0]        s_q, s_d;
  logic               cout_q, cout_d;
  logic               accept;

  // rca_36b: ripple chain fed only from the operand registers
  logic [36:0] carry;
  logic [35:0] sum;

  assign carry[0] = cr_q;
  for (genvar i = 0; i < 36; i++) begin : g_rca_36b
    assign sum[i]       = ar_q[i] ^ br_q[i] ^ carry[i];
    assign carry[i + 1] = (ar_q[i] & br_q[i]) | (carry[i] & (ar_q[i] ^ br_q[i]));
  end

`ifdef ADD36_OVF_EN
  logic ovf_q, ovf_d;
  assign Ovf = ovf_q;
`endif

  assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign out_valid = (state_q == StDone);
  assign accept    = in_valid && in_ready;
  assign S         = s_q;
  assign Cout      = cout_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ar_d    = ar_q;
    br_d    = br_q;
    cr_d    = cr_q;
    s_d     = s_q;
    cout_d  = cout_q;
`ifdef ADD36_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      StSettle: begin
        if (cnt_q == '0) begin
          s_d     = sum;
          cout_d  = carry[36];
`ifdef ADD36_OVF_EN
          ovf_d   = (ar_q[35] == br_q[35]) && (sum[35] != ar_q[35]);
`endif
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: ;
    endcase
    // Covers both a fresh accept from idle and a consume-and-accept in done
    if (accept) begin
      ar_d    = A;
      br_d    = sub ? ~B : B;
      cr_d    = sub;
      cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
      state_d = StSettle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ar_q    <= '0;
      br_q    <= '0;
      cr_q    <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
`ifdef ADD36_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ar_q    <= ar_d;
      br_q    <= br_d;
      cr_q    <= cr_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
`ifdef ADD36_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_add36_seq_ctrl.sv
// Scoreboard bench for add36_seq_ctrl: driver pushes hand-computed results, monitor pops on handshake.
module tb_add36_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [35:0] A;
  logic [35:0] B;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [35:0] S;
  logic        Cout;
`ifdef ADD36_OVF_EN
  logic        Ovf;
`endif

  int total = 0;
  int bad   = 0;
  logic [37:0] sb_q[$];  // {ovf, cout, s}

  always #5 clk = ~clk;

  add36_seq_ctrl #(.SETTLE_CYCLES(2), .CNT_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .S        (S),
    .Cout     (Cout)
`ifdef ADD36_OVF_EN
    ,
    .Ovf      (Ovf)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a handshake completes at the next rising edge
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got S=%0h with empty scoreboard", S);
      end else begin
        logic [37:0] e;
        e = sb_q.pop_front();
        check("result_S", {28'd0, S}, {28'd0, e[35:0]});
        check("result_Cout", {63'd0, Cout}, {63'd0, e[36]});
`ifdef ADD36_OVF_EN
        check("result_Ovf", {63'd0, Ovf}, {63'd0, e[37]});
`endif
      end
    end
  end

  task automatic wait_valid(input string name, input int exp_lat);
    int n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(name, 64'(n), 64'(exp_lat));
  endtask

  task automatic send(input logic [35:0] a, input logic [35:0] b, input logic s,
                      input logic [35:0] es, input logic ec, input logic eo);
    int n = 0;
    in_valid = 1'b1;
    A = a;
    B = b;
    sub = s;
    while (in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: in_ready=%0b expected 1", in_ready);
    end
    sb_q.push_back({eo, ec, es});
    tick();
    in_valid = 1'b0;
    A = '0;
    B = '0;
    sub = 1'b0;
    wait_valid("latency", 2);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    A = '0;
    B = '0;
    sub = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_S", {28'd0, S}, 64'd0);
    check("rst_Cout", {63'd0, Cout}, 64'd0);
    tick();

    send(36'h5, 36'h3, 1'b0, 36'h8, 1'b0, 1'b0);
    send(36'hF_FFFF_FFFF, 36'h1, 1'b0, 36'h0, 1'b1, 1'b0);
    send(36'h7_FFFF_FFFF, 36'h1, 1'b0, 36'h8_0000_0000, 1'b0, 1'b1);
    send(36'h3, 36'h5, 1'b1, 36'hF_FFFF_FFFE, 1'b0, 1'b0);
    send(36'h5, 36'h3, 1'b1, 36'h2, 1'b1, 1'b0);
    tick();

    // Backpressure: result must hold while inputs wiggle
    out_ready = 1'b0;
    send(36'h123, 36'h456, 1'b0, 36'h579, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      A = 36'(i * 17 + 9);
      B = 36'(i + 1);
      sub = i[0];
      tick();
      check("bp_S", {28'd0, S}, 64'h579);
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
      check("bp_out_valid", {63'd0, out_valid}, 64'd1);
    end
    // Consume and accept on the same edge
    A = 36'h1;
    B = 36'h1;
    sub = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    sb_q.push_back({1'b0, 1'b0, 36'h2});
    #1;
    check("b2b_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    check("b2b_out_valid_low", {63'd0, out_valid}, 64'd0);
    check("b2b_not_idle", {63'd0, in_ready}, 64'd0);
    wait_valid("b2b_latency", 2);
    tick();

    // Reset during settle drops the transaction
    A = 36'h7;
    B = 36'h7;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
      check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
      check("midrst_S", {28'd0, S}, 64'd0);
      tick();
    end
    send(36'h1, 36'h2, 1'b0, 36'h3, 1'b0, 1'b0);

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
    check("drain", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
